apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  APB initiator: turns a simple valid/ready command port (CPU/DMA side) into APB
//  SETUP/ACCESS transfers toward apb_sram and other APB responders.
//  Returns read data and error status on a valid/ready response port.
//  One transfer outstanding at a time.
//  A wait-state watchdog aborts transfers whose responder never asserts pready.
// PARAMETERS
//  N_WIDTH   32  data width of cmd_wdata/rsp_rdata/pwdata/prdata
//  N_ADDR    10  byte-address width of cmd_addr/paddr
//  TIMEOUT   16  max ACCESS cycles without pready before abort; 0 disables watchdog
// PORTS
//  pclk       in   1        clock
//  prstn      in   1        reset, asynchronous, active-low
//  cmd_valid  in   1        command request
//  cmd_ready  out  1        command accepted when cmd_valid&&cmd_ready
//  cmd_write  in   1        1=write, 0=read
//  cmd_addr   in   N_ADDR   byte address
//  cmd_wdata  in   N_WIDTH  write data
//  rsp_valid  out  1        response available
//  rsp_ready  in   1        response consumed when rsp_valid&&rsp_ready
//  rsp_rdata  out  N_WIDTH  read data; 0 for writes and aborted transfers
//  rsp_err    out  1        pslverr sampled at completion, or watchdog abort
//  psel       out  1        APB select
//  penable    out  1        APB enable
//  pwrite     out  1        APB direction
//  paddr      out  N_ADDR   APB address, word-aligned: {cmd_addr[N_ADDR-1:2],2'b00}
//  pwdata     out  N_WIDTH  APB write data
//  pready     in   1        responder ready
//  prdata     in   N_WIDTH  responder read data
//  pslverr    in   1        responder error; tie 0 for responders without it
// BEHAVIOUR
//  Reset (async, prstn=0): state IDLE; psel/penable/pwrite/paddr/pwdata/rsp_valid/
//   rsp_rdata/rsp_err=0; wait counter=0; cmd_ready=1 once in IDLE.
//  FSM, one-hot IDLE/SETUP/ACCESS/RESP:
//   IDLE:   cmd_ready=1. On cmd_valid: latch write/addr/wdata -> SETUP.
//   SETUP:  psel=1, penable=0, 1 cycle -> ACCESS.
//   ACCESS: psel=1, penable=1. pready=1: capture prdata (reads only) and pslverr -> RESP.
//           pready=0: cnt++. cnt==TIMEOUT-1 && TIMEOUT!=0 && !pready:
//           abort, rsp_err=1, rsp_rdata=0 -> RESP.
//   RESP:   psel=penable=0, rsp_valid=1, rsp_* held stable until rsp_ready -> IDLE.
//  All APB outputs are registered; no combinational path from cmd_* or pready to APB outputs.
//  pwrite/paddr/pwdata are stable from SETUP through the last ACCESS cycle.
//  Latency (zero-wait responder, pready=penable): accept at edge t, SETUP t+1,
//   ACCESS t+2, rsp_valid t+3, IDLE t+4 with rsp_ready=1.
//   Peak throughput is 1 transfer per 4 cycles.
//  Wait counter width $clog2(TIMEOUT+1); cleared on SETUP entry; never wraps.
//  cmd_* ignored outside IDLE; cmd_ready=0 in SETUP/ACCESS/RESP.
//  pslverr sampled only when ACCESS && pready; pready ignored outside ACCESS.
//  pready on the exact watchdog-limit cycle: transfer completes normally, no abort.
//  Reset mid-transfer: APB outputs drop to 0 immediately; no response is issued;
//   the latched command is discarded.
// STRUCTURE
//  apb_pkg: state localparams (one-hot), default N_WIDTH/N_ADDR, APB_ALIGN=2.
//  Sub-module apb_wait_timer: clear/enable/expired counter parameterised by TIMEOUT.
//  Top level holds the FSM, command/response registers and APB output flops.
// TESTING
//  1 Write 0xA5 to 0x10 into apb_sram: psel at t+1, penable at t+2, pwrite=1,
//    paddr=0x10, rsp_valid at t+3, rsp_err=0.
//  2 Read 0x10 back: rsp_rdata=0x000000A5, rsp_err=0; cmd_addr 0x13 also drives
//    paddr=0x10 and returns 0xA5.
//  3 Responder holds pready=0 for 3 ACCESS cycles, then pready=1 with pslverr=1:
//    penable high 4 cycles, paddr/pwdata stable, rsp_err=1.
//  4 TIMEOUT=8, pready stuck 0: abort after 8 ACCESS cycles, rsp_err=1, rsp_rdata=0,
//    psel=0 in RESP.
//  5 rsp_ready=0 for 5 cycles with cmd_valid=1: rsp_valid/rsp_rdata held, cmd_ready=0,
//    no new psel. Second command starts the cycle after rsp_ready.
//  6 Assert prstn mid-ACCESS: psel/penable/rsp_valid=0 asynchronously; after release,
//    cmd_ready=1 and next command runs normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB initiator.
// One-hot state encoding and default bus geometry.
package apb_pkg;

    localparam int N_WIDTH_DEF = 32;
    localparam int N_ADDR_DEF  = 10;
    localparam int APB_ALIGN   = 2;

    localparam int S_IDLE   = 0;
    localparam int S_SETUP  = 1;
    localparam int S_ACCESS = 2;
    localparam int S_RESP   = 3;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        SETUP  = 4'b0010,
        ACCESS = 4'b0100,
        RESP   = 4'b1000
    } state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state watchdog for the APB ACCESS phase.
// Saturating counter; expired marks the last allowed wait cycle.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic prstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt;

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command port to APB initiator bridge.
// One transfer in flight; watchdog aborts stalled responders.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int N_WIDTH = N_WIDTH_DEF,
    parameter int N_ADDR  = N_ADDR_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic               pclk,
    input  logic               prstn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [N_ADDR-1:0]  cmd_addr,
    input  logic [N_WIDTH-1:0] cmd_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [N_WIDTH-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [N_ADDR-1:0]  paddr,
    output logic [N_WIDTH-1:0] pwdata,
    input  logic               pready,
    input  logic [N_WIDTH-1:0] prdata,
    input  logic               pslverr
);

    state_t state, nxt;
    logic   accept, done, abort;
    logic   tmr_clr, tmr_en, tmr_exp;
    logic   unused_lo;

    assign unused_lo = ^cmd_addr[APB_ALIGN-1:0];
    assign cmd_ready = state[S_IDLE];
    assign accept    = state[S_IDLE] && cmd_valid;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .pclk    (pclk),
        .prstn   (prstn),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_exp)
    );

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt     = state;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        unique case (1'b1)
            state[S_IDLE]: begin
                if (cmd_valid) begin
                    nxt     = SETUP;
                    tmr_clr = 1'b1;
                end
            end
            state[S_SETUP]: begin
                nxt = ACCESS;
            end
            state[S_ACCESS]: begin
                // pready wins over the watchdog on the limit cycle
                if (pready) begin
                    nxt  = RESP;
                    done = 1'b1;
                end else if (tmr_exp) begin
                    nxt   = RESP;
                    abort = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            state[S_RESP]: begin
                if (rsp_ready) begin
                    nxt = IDLE;
                end
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            psel      <= nxt[S_SETUP] | nxt[S_ACCESS];
            penable   <= nxt[S_ACCESS];
            rsp_valid <= nxt[S_RESP];
            if (accept) begin
                pwrite <= cmd_write;
                paddr  <= {cmd_addr[N_ADDR-1:APB_ALIGN], {APB_ALIGN{1'b0}}};
                pwdata <= cmd_wdata;
            end
            if (done) begin
                rsp_rdata <= pwrite ? '0 : prdata;
                rsp_err   <= pslverr;
            end else if (abort) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge with a behavioural APB memory.
// Directed transfers: zero-wait, wait states, watchdog, backpressure, reset.
module tb_apb_master_bridge;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        pclk = 1'b0;
    logic        prstn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel, penable, pwrite;
    logic [9:0]  paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int   n_pass = 0;
    int   n_total = 0;
    rsp_t exp_q[$];

    logic [31:0] mem [256];
    int          wait_n = 0;
    bit          stuck = 1'b0;
    bit          err_mode = 1'b0;
    int          wcnt = 0;

    always #5 pclk = ~pclk;

    apb_master_bridge #(
        .N_WIDTH (32),
        .N_ADDR  (10),
        .TIMEOUT (8)
    ) dut (
        .pclk      (pclk),
        .prstn     (prstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr)
    );

    // Behavioural responder: wait_n stall cycles, optional error, or stuck.
    assign pready  = psel && penable && !stuck && (wcnt >= wait_n);
    assign pslverr = psel && penable && err_mode;
    assign prdata  = mem[paddr[9:2]];

    always @(posedge pclk) begin
        if (!(psel && penable)) begin
            wcnt <= 0;
        end else if (!pready) begin
            wcnt <= wcnt + 1;
        end
        if (psel && penable && pready && pwrite) begin
            mem[paddr[9:2]] <= pwdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    initial begin
        rsp_t e;
        forever begin
            @(negedge pclk);
            #2;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL rsp_unexpected: got rdata %h err %b, required no response",
                             rsp_rdata, rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] rd, input logic err);
        rsp_t r;
        r.rdata = rd;
        r.err   = err;
        exp_q.push_back(r);
    endtask

    // Issue one command at a negedge; returns at the SETUP-cycle negedge.
    task automatic send(input logic w, input logic [9:0] a, input logic [31:0] d,
                        input logic [9:0] exp_pa, input logic [31:0] exp_rd,
                        input logic exp_err, input bit expect_rsp);
        int n;
        if (expect_rsp) push_exp(exp_rd, exp_err);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 40) begin
            @(negedge pclk);
            n++;
        end
        if (!cmd_ready) begin
            n_total++;
            $display("FAIL cmd_accept: got cmd_ready 0, required 1");
        end
        @(negedge pclk);
        cmd_valid = 1'b0;
        check("setup_psel_penable", {30'd0, psel, penable}, 32'h2);
        check("setup_paddr", {22'd0, paddr}, {22'd0, exp_pa});
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 100) begin
            @(negedge pclk);
            n++;
        end
        if (n >= 100) begin
            n_total++;
            $display("FAIL wait_done: got %0d pending responses, required 0", exp_q.size());
        end
    endtask

    task automatic count_access(output int n, output bit stable,
                                input logic [9:0] pa, input logic [31:0] pd);
        n = 0;
        stable = 1'b1;
        @(negedge pclk);
        while (penable && n < 40) begin
            n++;
            if (paddr !== pa || pwdata !== pd) stable = 1'b0;
            @(negedge pclk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, required completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int  n;
        bit  stable;
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
        prstn     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge pclk);
        check("reset_apb", {29'd0, psel, penable, pwrite}, 32'h0);
        check("reset_paddr", {22'd0, paddr}, 32'h0);
        check("reset_rsp", {31'd0, rsp_valid}, 32'h0);
        check("reset_rdata", rsp_rdata, 32'h0);
        prstn = 1'b1;
        @(negedge pclk);
        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'h1);

        // 1: zero-wait write, cycle-by-cycle timing
        send(1'b1, 10'h010, 32'hA5, 10'h010, 32'h0, 1'b0, 1'b1);
        check("t1_pwrite", {31'd0, pwrite}, 32'h1);
        check("t1_cmd_ready_busy", {31'd0, cmd_ready}, 32'h0);
        @(negedge pclk);
        check("t1_access", {30'd0, psel, penable}, 32'h3);
        check("t1_pwdata", pwdata, 32'hA5);
        @(negedge pclk);
        check("t1_resp_valid", {31'd0, rsp_valid}, 32'h1);
        check("t1_resp_psel", {30'd0, psel, penable}, 32'h0);
        wait_done();

        // 2: read back, aligned and unaligned address
        send(1'b0, 10'h010, 32'h0, 10'h010, 32'hA5, 1'b0, 1'b1);
        wait_done();
        send(1'b0, 10'h013, 32'h0, 10'h010, 32'hA5, 1'b0, 1'b1);
        wait_done();

        // 3: three wait states then slave error
        wait_n   = 3;
        err_mode = 1'b1;
        send(1'b1, 10'h020, 32'h12345678, 10'h020, 32'h0, 1'b1, 1'b1);
        count_access(n, stable, 10'h020, 32'h12345678);
        check("t3_penable_cycles", n, 32'd4);
        check("t3_stable", {31'd0, stable}, 32'h1);
        wait_done();
        wait_n   = 0;
        err_mode = 1'b0;

        // 4: stuck responder hits the watchdog
        stuck = 1'b1;
        send(1'b0, 10'h030, 32'h0, 10'h030, 32'h0, 1'b1, 1'b1);
        count_access(n, stable, 10'h030, 32'h0);
        check("t4_penable_cycles", n, 32'd8);
        check("t4_resp_psel", {31'd0, psel}, 32'h0);
        check("t4_resp_valid", {31'd0, rsp_valid}, 32'h1);
        wait_done();
        stuck = 1'b0;

        // 5: response backpressure with a second command waiting
        rsp_ready = 1'b0;
        send(1'b0, 10'h010, 32'h0, 10'h010, 32'hA5, 1'b0, 1'b1);
        push_exp(32'h0, 1'b0);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 10'h040;
        cmd_wdata = 32'h55;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge pclk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", {31'd0, rsp_valid}, 32'h1);
            check("t5_hold_rdata", rsp_rdata, 32'hA5);
            check("t5_hold_cmd_ready", {31'd0, cmd_ready}, 32'h0);
            check("t5_hold_psel", {31'd0, psel}, 32'h0);
            @(negedge pclk);
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        check("t5_idle_cmd_ready", {31'd0, cmd_ready}, 32'h1);
        check("t5_idle_psel", {31'd0, psel}, 32'h0);
        @(negedge pclk);
        cmd_valid = 1'b0;
        check("t5_second_setup", {30'd0, psel, penable}, 32'h2);
        check("t5_second_paddr", {22'd0, paddr}, 32'h040);
        wait_done();
        send(1'b0, 10'h040, 32'h0, 10'h040, 32'h55, 1'b0, 1'b1);
        wait_done();

        // 6: reset in the middle of ACCESS
        send(1'b1, 10'h050, 32'h77, 10'h050, 32'h0, 1'b0, 1'b0);
        @(negedge pclk);
        check("t6_in_access", {31'd0, penable}, 32'h1);
        #1;
        prstn = 1'b0;
        #1;
        check("t6_async_drop", {29'd0, psel, penable, rsp_valid}, 32'h0);
        exp_q.delete();
        @(negedge pclk);
        check("t6_no_write", mem[20], 32'hC0DE0014);
        check("t6_rsp_err", {31'd0, rsp_err}, 32'h0);
        prstn = 1'b1;
        check("t6_cmd_ready", {31'd0, cmd_ready}, 32'h1);
        @(negedge pclk);
        send(1'b0, 10'h010, 32'h0, 10'h010, 32'hA5, 1'b0, 1'b1);
        wait_done();
        repeat (3) @(negedge pclk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
